// File: rtl/ant_nav_ctrl.sv
// rtl/ant_nav_ctrl.sv - wall-following maze ant navigation controller; pheromone trail marking under ANT_PHEROMONE_EN
module ant_nav_ctrl #(
    parameter int         FOLLOW_SIDE = 0,
    parameter int         TURN_CYC    = 1,
    parameter int         HIT_WAIT    = 4,
    parameter int         STEP_W      = 16,
    parameter int         PH_WIDTH    = 2,
    parameter int         PH_CODE     = 1,
    parameter logic [1:0] MV_HALT     = 2'b00,
    parameter logic [1:0] MV_RIGHT    = 2'b01,
    parameter logic [1:0] MV_LEFT     = 2'b10,
    parameter logic [1:0] MV_FWD      = 2'b11
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ant_l,
    input  logic                ant_r,
    input  logic                hit,
    input  logic                escape,
`ifdef ANT_PHEROMONE_EN
    input  logic [PH_WIDTH-1:0] ph_detected,
    output logic [PH_WIDTH-1:0] ph_drop,
`endif
    output logic [1:0]          move,
    output logic                escaped,
    output logic [STEP_W-1:0]   step_cnt
);

    // Reject configurations the controller cannot honour (zero-length holds, empty trail mark).
    if (TURN_CYC < 1 || HIT_WAIT < 1 || PH_WIDTH < 1 || PH_CODE == 0) begin : g_bad_cfg
        $error("ant_nav_ctrl: invalid parameter set");
    end

    localparam int TMAX = (TURN_CYC > HIT_WAIT) ? TURN_CYC : HIT_WAIT;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] T_TURN = TW'(TURN_CYC);
    localparam logic [TW-1:0] T_HIT  = TW'(HIT_WAIT);
    localparam logic [TW-1:0] T_ONE  = TW'(1);

    // Mirroring the follow side swaps which antenna is the wall and which turn is "away".
    localparam logic [1:0] MV_AWAY   = (FOLLOW_SIDE != 0) ? MV_LEFT  : MV_RIGHT;
    localparam logic [1:0] MV_TOWARD = (FOLLOW_SIDE != 0) ? MV_RIGHT : MV_LEFT;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FWD,
        S_TAWAY,
        S_SETTLE,
        S_TTOWARD,
        S_BACKOFF,
        S_ESC
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          move_q, move_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                escaped_q, escaped_d;
    logic [STEP_W-1:0]   step_q, step_d;

    state_t              dec_state;
    logic [1:0]          dec_move;
    logic [TW-1:0]       dec_timer;

    logic                wall;
    logic                front;
    logic                ph_seen;

    assign wall  = (FOLLOW_SIDE != 0) ? ant_r : ant_l;
    assign front = (FOLLOW_SIDE != 0) ? ant_l : ant_r;

`ifdef ANT_PHEROMONE_EN
    localparam logic [PH_WIDTH-1:0] PH_VAL = PH_WIDTH'(PH_CODE);

    logic [PH_WIDTH-1:0] ph_drop_q, ph_drop_d;

    assign ph_seen = |ph_detected;
`else
    assign ph_seen = 1'b0;
`endif

    // Prioritised navigation decision from the current sensor sample.
    always_comb begin
        dec_state = S_TTOWARD;
        dec_move  = MV_TOWARD;
        dec_timer = T_TURN;
        if (escape) begin
            dec_state = S_ESC;
            dec_move  = MV_HALT;
            dec_timer = '0;
        end else if (hit) begin
            dec_state = S_BACKOFF;
            dec_move  = MV_HALT;
            dec_timer = T_HIT;
        end else if (front || (wall && ph_seen)) begin
            dec_state = S_TAWAY;
            dec_move  = MV_AWAY;
            dec_timer = T_TURN;
        end else if (wall) begin
            dec_state = S_FWD;
            dec_move  = MV_FWD;
            dec_timer = '0;
        end
    end

    // Next state, move, hold timer, escape latch and step count.
    always_comb begin
        state_d   = state_q;
        move_d    = move_q;
        timer_d   = timer_q;
        unique case (state_q)
            S_IDLE, S_FWD, S_SETTLE: begin
                state_d = dec_state;
                move_d  = dec_move;
                timer_d = dec_timer;
            end
            S_TAWAY: begin
                if (escape || hit) begin
                    state_d = dec_state;
                    move_d  = dec_move;
                    timer_d = dec_timer;
                end else if (timer_q <= T_ONE) begin
                    state_d = S_SETTLE;
                    move_d  = MV_HALT;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - T_ONE;
                end
            end
            S_TTOWARD: begin
                if (escape || hit) begin
                    state_d = dec_state;
                    move_d  = dec_move;
                    timer_d = dec_timer;
                end else if (timer_q <= T_ONE) begin
                    // One forced step after turning toward the wall, no wall check.
                    state_d = S_FWD;
                    move_d  = MV_FWD;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - T_ONE;
                end
            end
            S_BACKOFF: begin
                if (escape) begin
                    state_d = S_ESC;
                    move_d  = MV_HALT;
                    timer_d = '0;
                end else if (hit) begin
                    timer_d = T_HIT;
                end else if (timer_q <= T_ONE) begin
                    state_d = S_TAWAY;
                    move_d  = MV_AWAY;
                    timer_d = T_TURN;
                end else begin
                    timer_d = timer_q - T_ONE;
                end
            end
            S_ESC: begin
                move_d  = MV_HALT;
                timer_d = '0;
            end
            default: begin
                state_d = S_IDLE;
                move_d  = MV_HALT;
                timer_d = '0;
            end
        endcase

        escaped_d = escaped_q | (state_d == S_ESC);

        step_d = step_q;
        if (state_q != S_ESC && move_d == MV_FWD && step_q != {STEP_W{1'b1}}) begin
            step_d = step_q + STEP_W'(1);
        end
    end

    // Controller registers; reset drops straight back to IDLE with a halt command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            move_q    <= MV_HALT;
            timer_q   <= '0;
            escaped_q <= 1'b0;
            step_q    <= '0;
        end else begin
            state_q   <= state_d;
            move_q    <= move_d;
            timer_q   <= timer_d;
            escaped_q <= escaped_d;
            step_q    <= step_d;
        end
    end

`ifdef ANT_PHEROMONE_EN
    // Mark the trail on forward steps into cells that carry no pheromone yet.
    always_comb begin
        ph_drop_d = '0;
        if (move_d == MV_FWD && ph_detected == '0) begin
            ph_drop_d = PH_VAL;
        end
    end

    // Trail deposit register, aligned with the move register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_drop_q <= '0;
        end else begin
            ph_drop_q <= ph_drop_d;
        end
    end

    assign ph_drop = ph_drop_q;
`endif

    assign move     = move_q;
    assign escaped  = escaped_q;
    assign step_cnt = step_q;

endmodule

// File: tb/tb_ant_nav_ctrl.sv
// tb/tb_ant_nav_ctrl.sv - scoreboard bench for ant_nav_ctrl (left-follow and right-follow instances)
module tb_ant_nav_ctrl;

    localparam logic [1:0] H = 2'b00;
    localparam logic [1:0] R = 2'b01;
    localparam logic [1:0] L = 2'b10;
    localparam logic [1:0] F = 2'b11;

    logic       clk;
    logic       rst_n;
    logic       a_l, a_r, a_h, a_e;
    logic       b_l, b_r, b_h, b_e;
    logic [1:0] a_move, b_move;
    logic       a_esc, b_esc;
    logic [3:0] a_step;
    logic [7:0] b_step;
`ifdef ANT_PHEROMONE_EN
    logic [1:0] a_ph_in, b_ph_in;
    logic [1:0] a_ph_out, b_ph_out;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        bit         sel;
        logic [1:0] mv;
        logic       esc;
        int         step;
        logic [1:0] ph;
    } exp_t;

    exp_t sb[$];

    ant_nav_ctrl #(
        .FOLLOW_SIDE(0), .TURN_CYC(3), .HIT_WAIT(4), .STEP_W(4), .PH_WIDTH(2), .PH_CODE(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .ant_l(a_l), .ant_r(a_r), .hit(a_h), .escape(a_e),
`ifdef ANT_PHEROMONE_EN
        .ph_detected(a_ph_in), .ph_drop(a_ph_out),
`endif
        .move(a_move), .escaped(a_esc), .step_cnt(a_step)
    );

    ant_nav_ctrl #(
        .FOLLOW_SIDE(1), .TURN_CYC(1), .HIT_WAIT(2), .STEP_W(8), .PH_WIDTH(2), .PH_CODE(2)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .ant_l(b_l), .ant_r(b_r), .hit(b_h), .escape(b_e),
`ifdef ANT_PHEROMONE_EN
        .ph_detected(b_ph_in), .ph_drop(b_ph_out),
`endif
        .move(b_move), .escaped(b_esc), .step_cnt(b_step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected outputs, then compare after the edge.
    task automatic tick(input string tag, input bit sel, input bit l, input bit r, input bit h,
                        input bit e, input logic [1:0] ph, input logic [1:0] emv, input bit eesc,
                        input int estep);
        exp_t x;
        if (sel) begin
            b_l = l; b_r = r; b_h = h; b_e = e;
        end else begin
            a_l = l; a_r = r; a_h = h; a_e = e;
        end
`ifdef ANT_PHEROMONE_EN
        if (sel) b_ph_in = ph; else a_ph_in = ph;
`endif
        x.tag  = tag;
        x.sel  = sel;
        x.mv   = emv;
        x.esc  = eesc;
        x.step = estep;
        x.ph   = (emv == F && ph == 2'b00) ? (sel ? 2'd2 : 2'd1) : 2'd0;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        if (x.sel) begin
            check({x.tag, "/mv"},   32'(b_move), 32'(x.mv));
            check({x.tag, "/esc"},  32'(b_esc),  32'(x.esc));
            check({x.tag, "/step"}, 32'(b_step), 32'(x.step));
`ifdef ANT_PHEROMONE_EN
            check({x.tag, "/ph"},   32'(b_ph_out), 32'(x.ph));
`endif
        end else begin
            check({x.tag, "/mv"},   32'(a_move), 32'(x.mv));
            check({x.tag, "/esc"},  32'(a_esc),  32'(x.esc));
            check({x.tag, "/step"}, 32'(a_step), 32'(x.step));
`ifdef ANT_PHEROMONE_EN
            check({x.tag, "/ph"},   32'(a_ph_out), 32'(x.ph));
`endif
        end
    endtask

    // Assert reset between edges and verify the asynchronous clear before any clock edge.
    task automatic reset_all(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, "/a_mv"},   32'(a_move), 32'(H));
        check({tag, "/a_esc"},  32'(a_esc),  32'(0));
        check({tag, "/a_step"}, 32'(a_step), 32'(0));
        check({tag, "/b_mv"},   32'(b_move), 32'(H));
        check({tag, "/b_esc"},  32'(b_esc),  32'(0));
        check({tag, "/b_step"}, 32'(b_step), 32'(0));
`ifdef ANT_PHEROMONE_EN
        check({tag, "/a_ph"},   32'(a_ph_out), 32'(0));
        check({tag, "/b_ph"},   32'(b_ph_out), 32'(0));
        a_ph_in = '0; b_ph_in = '0;
`endif
        a_l = 0; a_r = 0; a_h = 0; a_e = 0;
        b_l = 0; b_r = 0; b_h = 0; b_e = 0;
        @(posedge clk);
        #1;
        check({tag, "/idle_a"}, 32'(a_move), 32'(H));
        check({tag, "/idle_b"}, 32'(b_move), 32'(H));
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1;
        a_l = 0; a_r = 0; a_h = 0; a_e = 0;
        b_l = 0; b_r = 0; b_h = 0; b_e = 0;
`ifdef ANT_PHEROMONE_EN
        a_ph_in = '0; b_ph_in = '0;
`endif
        @(posedge clk);
        #1;

        // Straight wall on the left: forward every cycle, step count saturates at 15.
        reset_all("rst0");
        for (int k = 1; k <= 17; k++) begin
            tick("fwd", 0, 1, 0, 0, 0, 2'b00, F, 0, (k > 15) ? 15 : k);
        end

        // Front contact (with wall too): three right-turn cycles, settle, then forward.
        reset_all("rst1");
        tick("taway0", 0, 1, 0, 0, 0, 2'b00, F, 0, 1);
        tick("taway1", 0, 1, 1, 0, 0, 2'b00, R, 0, 1);
        tick("taway2", 0, 1, 1, 0, 0, 2'b00, R, 0, 1);
        tick("taway3", 0, 1, 0, 0, 0, 2'b00, R, 0, 1);
        tick("settle", 0, 1, 0, 0, 0, 2'b00, H, 0, 1);
        tick("redec",  0, 1, 0, 0, 0, 2'b00, F, 0, 2);
        // Wall lost: three left-turn cycles, then one forced forward step.
        tick("ttow1",  0, 0, 0, 0, 0, 2'b00, L, 0, 2);
        tick("ttow2",  0, 0, 0, 0, 0, 2'b00, L, 0, 2);
        tick("ttow3",  0, 0, 0, 0, 0, 2'b00, L, 0, 2);
        tick("forced", 0, 0, 0, 0, 0, 2'b00, F, 0, 3);
        tick("fwd_b",  0, 1, 0, 0, 0, 2'b00, F, 0, 4);

        // Right-follow instance, single-cycle turns, two-cycle back-off.
        reset_all("rst2");
        tick("m_fwd",   1, 0, 1, 0, 0, 2'b00, F, 0, 1);
        tick("m_tow",   1, 0, 0, 0, 0, 2'b00, R, 0, 1);
        tick("m_force", 1, 0, 0, 0, 0, 2'b00, F, 0, 2);
        tick("m_tow2",  1, 0, 0, 0, 0, 2'b00, R, 0, 2);
        tick("m_force2",1, 0, 1, 0, 0, 2'b00, F, 0, 3);
        tick("m_fwd2",  1, 0, 1, 0, 0, 2'b00, F, 0, 4);
        tick("m_both",  1, 1, 1, 0, 0, 2'b00, L, 0, 4);
        tick("m_settle",1, 0, 1, 0, 0, 2'b00, H, 0, 4);
        tick("m_fwd3",  1, 0, 1, 0, 0, 2'b00, F, 0, 5);
        tick("m_hit",   1, 0, 1, 1, 0, 2'b00, H, 0, 5);
        tick("m_boff",  1, 0, 1, 0, 0, 2'b00, H, 0, 5);
        tick("m_away",  1, 0, 1, 0, 0, 2'b00, L, 0, 5);
        tick("m_settl2",1, 0, 1, 0, 0, 2'b00, H, 0, 5);
        tick("m_fwd4",  1, 0, 1, 0, 0, 2'b00, F, 0, 6);
        tick("m_esc",   1, 0, 1, 0, 1, 2'b00, H, 1, 6);
        tick("m_eshold",1, 0, 1, 0, 0, 2'b00, H, 1, 6);

        // Hit back-off with a re-hit in its second cycle: six halts, then turn away.
        reset_all("rst3");
        tick("h_fwd",  0, 1, 0, 0, 0, 2'b00, F, 0, 1);
        tick("h_c1",   0, 1, 0, 1, 0, 2'b00, H, 0, 1);
        tick("h_c2",   0, 1, 0, 0, 0, 2'b00, H, 0, 1);
        tick("h_c3",   0, 1, 0, 1, 0, 2'b00, H, 0, 1);
        tick("h_c4",   0, 1, 0, 0, 0, 2'b00, H, 0, 1);
        tick("h_c5",   0, 1, 0, 0, 0, 2'b00, H, 0, 1);
        tick("h_c6",   0, 1, 0, 0, 0, 2'b00, H, 0, 1);
        tick("h_aw1",  0, 1, 0, 0, 0, 2'b00, R, 0, 1);
        tick("h_aw2",  0, 1, 0, 0, 0, 2'b00, R, 0, 1);
        tick("h_aw3",  0, 1, 0, 0, 0, 2'b00, R, 0, 1);
        tick("h_settl",0, 1, 0, 0, 0, 2'b00, H, 0, 1);
        tick("h_fwd2", 0, 1, 0, 0, 0, 2'b00, F, 0, 2);
        // Escape (with a simultaneous hit) during a turn: halt and latch until reset.
        tick("e_turn", 0, 1, 1, 0, 0, 2'b00, R, 0, 2);
        tick("e_esc",  0, 1, 1, 1, 1, 2'b00, H, 1, 2);
        tick("e_hold1",0, 1, 0, 0, 0, 2'b00, H, 1, 2);
        tick("e_hold2",0, 0, 0, 0, 0, 2'b00, H, 1, 2);
        tick("e_hold3",0, 0, 1, 1, 0, 2'b00, H, 1, 2);
        reset_all("rst4");

`ifdef ANT_PHEROMONE_EN
        // Trail marking: drop on clean forward cells, turn away from marked wall cells.
        tick("p_fwd",  0, 1, 0, 0, 0, 2'b00, F, 0, 1);
        tick("p_seen", 0, 1, 0, 0, 0, 2'b01, R, 0, 1);
        tick("p_aw2",  0, 1, 0, 0, 0, 2'b00, R, 0, 1);
        tick("p_aw3",  0, 1, 0, 0, 0, 2'b00, R, 0, 1);
        tick("p_settl",0, 1, 0, 0, 0, 2'b00, H, 0, 1);
        tick("p_fwd2", 0, 1, 0, 0, 0, 2'b00, F, 0, 2);
        reset_all("rst5");
        tick("q_fwd",  1, 0, 1, 0, 0, 2'b00, F, 0, 1);
        tick("q_tow",  1, 0, 0, 0, 0, 2'b00, R, 0, 1);
        tick("q_force",1, 0, 1, 0, 0, 2'b11, F, 0, 2);
        tick("q_seen", 1, 0, 1, 0, 0, 2'b10, L, 0, 2);
`endif

        if (sb.size() != 0) begin
            check("sb_empty", 32'(sb.size()), 32'(0));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
